// File: rtl/cdb_result_arbiter_if.sv
// Bundle of the two functional-unit result channels and the shared CDB broadcast.
// master = producers/consumers around the arbiter, slave = the arbiter itself.
interface cdb_result_arbiter_if #(
    parameter int CNT_W = 3
);
    logic [15:0]      sumsub_result;
    logic             sumsub_valid;
    logic             sumsub_ready;
    logic [15:0]      ldsd_result;
    logic             ldsd_valid;
    logic             ldsd_ready;
    logic [15:0]      cdb;
    logic             cdb_valid;
    logic [CNT_W-1:0] sumsub_count;
    logic [CNT_W-1:0] ldsd_count;
    logic             drop_error;

    modport master (
        output sumsub_result, sumsub_valid, ldsd_result, ldsd_valid,
        input  sumsub_ready, ldsd_ready, cdb, cdb_valid,
               sumsub_count, ldsd_count, drop_error
    );

    modport slave (
        input  sumsub_result, sumsub_valid, ldsd_result, ldsd_valid,
        output sumsub_ready, ldsd_ready, cdb, cdb_valid,
               sumsub_count, ldsd_count, drop_error
    );
endinterface

// File: rtl/cdb_result_arbiter.sv
// Per-source result FIFOs feeding a single registered 16-bit CDB, round-robin granted.
// Define CDB_FIXED_PRIORITY_EN to make the ULA source always win ties instead.
module cdb_result_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    cdb_result_arbiter_if.slave  bus
);
    localparam int NUM_SRC = 2;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ULA     = 0;
    localparam int LDSD    = 1;

    logic [NUM_SRC-1:0][15:0]      in_word;
    logic [NUM_SRC-1:0][15:0]      head;
    logic [NUM_SRC-1:0][CNT_W-1:0] count;
    logic [NUM_SRC-1:0]            in_vld;
    logic [NUM_SRC-1:0]            full;
    logic [NUM_SRC-1:0]            empty;
    logic [NUM_SRC-1:0]            push;
    logic [NUM_SRC-1:0]            grant;

    logic [15:0] cdb_q;
    logic        cdb_valid_q;
    logic        drop_q;

    assign in_word = {bus.ldsd_result, bus.sumsub_result};
    assign in_vld  = {bus.ldsd_valid,  bus.sumsub_valid};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [DEPTH-1:0][15:0] mem;
        logic [PTR_W-1:0]       wr_ptr;
        logic [PTR_W-1:0]       rd_ptr;
        logic [CNT_W-1:0]       cnt;

        assign count[s] = cnt;
        assign full[s]  = (cnt == CNT_W'(DEPTH));
        assign empty[s] = (cnt == '0);
        // Ready looks only at full, so a full FIFO refuses a push even while popping.
        assign push[s]  = in_vld[s] && !full[s];
        assign head[s]  = mem[rd_ptr];

        always_ff @(posedge clock) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[s]) begin
                    mem[wr_ptr] <= in_word[s];
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (grant[s])
                    rd_ptr <= rd_ptr + 1'b1;
                cnt <= cnt + CNT_W'(push[s]) - CNT_W'(grant[s]);
            end
        end
    end

`ifdef CDB_FIXED_PRIORITY_EN
    always_comb begin
        grant = '0;
        if (!empty[ULA])
            grant[ULA] = 1'b1;
        else if (!empty[LDSD])
            grant[LDSD] = 1'b1;
    end
`else
    logic last_ldsd;

    // Ties go to whichever source was not granted last.
    always_comb begin
        grant = '0;
        if (!empty[ULA] && !empty[LDSD]) begin
            if (last_ldsd)
                grant[ULA] = 1'b1;
            else
                grant[LDSD] = 1'b1;
        end else if (!empty[ULA]) begin
            grant[ULA] = 1'b1;
        end else if (!empty[LDSD]) begin
            grant[LDSD] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            last_ldsd <= 1'b1;
        else if (|grant)
            last_ldsd <= grant[LDSD];
    end
`endif

    // Bit 10 is overwritten with the granting source so consumers can tell units apart.
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            if (grant[ULA]) begin
                cdb_q       <= {head[ULA][15:11], 1'b1, head[ULA][9:0]};
                cdb_valid_q <= 1'b1;
            end else if (grant[LDSD]) begin
                cdb_q       <= {head[LDSD][15:11], 1'b0, head[LDSD][9:0]};
                cdb_valid_q <= 1'b1;
            end else begin
                cdb_q       <= '0;
                cdb_valid_q <= 1'b0;
            end
            if (|(in_vld & full))
                drop_q <= 1'b1;
        end
    end

    assign bus.sumsub_ready = !full[ULA];
    assign bus.ldsd_ready   = !full[LDSD];
    assign bus.sumsub_count = count[ULA];
    assign bus.ldsd_count   = count[LDSD];
    assign bus.cdb          = cdb_q;
    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.drop_error   = drop_q;
endmodule
